// File: rtl/mips_multicycle_control_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
//   Op, Zero        : datapath -> controller (opcode from IR[31:26], ALU zero flag)
//   IRWrite..PCSrc  : controller -> datapath enables and mux selects
//   IllegalOp       : one-cycle flag for an unsupported opcode seen in DECODE
//   State           : current controller state, for debug
// The controller uses modport master; the datapath (or a bench) uses slave.
interface mips_multicycle_control_if;
  logic [5:0] Op;
  logic       Zero;
  logic       IRWrite;
  logic       PCWrite;
  logic       Branch;
  logic       PCEn;
  logic       MemWrite;
  logic       IorD;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSrc;
  logic       IllegalOp;
  logic [3:0] State;

  modport master (
    input  Op, Zero,
    output IRWrite, PCWrite, Branch, PCEn, MemWrite, IorD, RegWrite, RegDst,
           MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc, IllegalOp, State
  );

  modport slave (
    output Op, Zero,
    input  IRWrite, PCWrite, Branch, PCEn, MemWrite, IorD, RegWrite, RegDst,
           MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc, IllegalOp, State
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main controller for the multicycle MIPS datapath: a Moore FSM that walks each
// instruction through fetch, decode, execute, memory and writeback.
//   clk   : datapath clock, state advances on rising edge
//   rst_n : asynchronous active-low reset (forces IDLE, all strobes low)
//   ctl   : control bus (master side), see mips_multicycle_control_if
// All outputs decode from the registered state, except PCEn (combinational on
// Zero) and IllegalOp (combinational on Op while in DECODE).
module mips_multicycle_control (
  input  logic                        clk,
  input  logic                        rst_n,
  mips_multicycle_control_if.master   ctl
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEMADR  = 4'd3,
    MEMRD   = 4'd4,
    MEMWB   = 4'd5,
    MEMWR   = 4'd6,
    EXECUTE = 4'd7,
    ALUWB   = 4'd8,
    BRANCH  = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11,
    JUMP    = 4'd12
  } state_t;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal;
  } ctrl_t;

  state_t state, state_nxt;
  ctrl_t  c;
  logic   go_q;

  // go_q holds IDLE for one full cycle after reset release, so the first
  // FETCH never coincides with the edge that follows the deassertion; the
  // datapath always sees one quiet cycle before the first IR load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      go_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      go_q  <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = FETCH;
    c         = '0;
    case (state)
      IDLE:    state_nxt = go_q ? FETCH : IDLE;
      FETCH: begin
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = 2'b01;
        state_nxt   = DECODE;
      end
      DECODE: begin
        c.alu_src_b = 2'b11;
        case (ctl.Op)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_RTYPE:     state_nxt = EXECUTE;
          OP_BEQ:       state_nxt = BRANCH;
          OP_ADDI:      state_nxt = ADDIEX;
          OP_J:         state_nxt = JUMP;
          default: begin
            c.illegal = 1'b1;
            state_nxt = FETCH;
          end
        endcase
      end
      MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        // Op is re-sampled here; anything other than lw/sw abandons the access.
        if (ctl.Op == OP_LW)      state_nxt = MEMRD;
        else if (ctl.Op == OP_SW) state_nxt = MEMWR;
        else                      state_nxt = FETCH;
      end
      MEMRD: begin
        c.iord    = 1'b1;
        state_nxt = MEMWB;
      end
      MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
        state_nxt   = ALUWB;
      end
      ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b01;
        c.pc_src    = 2'b01;
        c.branch    = 1'b1;
      end
      ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        state_nxt   = ADDIWB;
      end
      ADDIWB:  c.reg_write = 1'b1;
      JUMP: begin
        c.pc_src   = 2'b10;
        c.pc_write = 1'b1;
      end
      default: state_nxt = FETCH;  // unused codes 13-15 recover via FETCH
    endcase
  end

  assign ctl.IRWrite   = c.ir_write;
  assign ctl.PCWrite   = c.pc_write;
  assign ctl.Branch    = c.branch;
  assign ctl.PCEn      = c.pc_write | (c.branch & ctl.Zero);
  assign ctl.MemWrite  = c.mem_write;
  assign ctl.IorD      = c.iord;
  assign ctl.RegWrite  = c.reg_write;
  assign ctl.RegDst    = c.reg_dst;
  assign ctl.MemtoReg  = c.mem_to_reg;
  assign ctl.ALUSrcA   = c.alu_src_a;
  assign ctl.ALUSrcB   = c.alu_src_b;
  assign ctl.ALUOp     = c.alu_op;
  assign ctl.PCSrc     = c.pc_src;
  assign ctl.IllegalOp = c.illegal;
  assign ctl.State     = state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control. The stimulus process issues
// one instruction at a time and pushes the expected per-cycle control word
// for the whole instruction; the monitor pops one entry every falling edge.
module tb_mips_multicycle_control;

  typedef struct packed {
    logic [3:0] st;
    logic       irw, pcw, br, pcen, mw, iord, rw, rdst, m2r, asa;
    logic [1:0] asb, aop, pcs;
    logic       ill;
  } exp_t;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mips_multicycle_control_if bus ();

  mips_multicycle_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (bus)
  );

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  function automatic exp_t actual();
    exp_t a;
    a.st = bus.State;  a.irw = bus.IRWrite; a.pcw = bus.PCWrite;
    a.br = bus.Branch; a.pcen = bus.PCEn;   a.mw = bus.MemWrite;
    a.iord = bus.IorD; a.rw = bus.RegWrite; a.rdst = bus.RegDst;
    a.m2r = bus.MemtoReg; a.asa = bus.ALUSrcA; a.asb = bus.ALUSrcB;
    a.aop = bus.ALUOp; a.pcs = bus.PCSrc;   a.ill = bus.IllegalOp;
    return a;
  endfunction

  // Control word the datapath needs in each step of an instruction.
  function automatic exp_t spec_out(input int s, input bit z, input bit ill);
    exp_t e = '0;
    e.st = 4'(s);
    case (s)
      1:  begin e.irw = 1; e.pcw = 1; e.pcen = 1; e.asb = 2'b01; end
      2:  begin e.asb = 2'b11; e.ill = ill; end
      3:  begin e.asa = 1; e.asb = 2'b10; end
      4:  e.iord = 1;
      5:  begin e.m2r = 1; e.rw = 1; end
      6:  begin e.iord = 1; e.mw = 1; end
      7:  begin e.asa = 1; e.aop = 2'b10; end
      8:  begin e.rdst = 1; e.rw = 1; end
      9:  begin e.asa = 1; e.aop = 2'b01; e.pcs = 2'b01; e.br = 1; e.pcen = z; end
      10: begin e.asa = 1; e.asb = 2'b10; end
      11: e.rw = 1;
      12: begin e.pcs = 2'b10; e.pcw = 1; e.pcen = 1; end
      default: ;
    endcase
    return e;
  endfunction

  // Step sequence an opcode takes, starting at FETCH.
  function automatic int path_state(input logic [5:0] op, input int c);
    int p[5];
    case (op)
      LW:      p = '{1, 2, 3, 4, 5};
      SW:      p = '{1, 2, 3, 6, 0};
      RT:      p = '{1, 2, 7, 8, 0};
      BEQ:     p = '{1, 2, 9, 0, 0};
      ADDI:    p = '{1, 2, 10, 11, 0};
      JMP:     p = '{1, 2, 12, 0, 0};
      default: p = '{1, 2, 0, 0, 0};
    endcase
    return p[c];
  endfunction

  function automatic int path_len(input logic [5:0] op);
    case (op)
      LW:                 return 5;
      SW, RT, ADDI:       return 4;
      BEQ, JMP:           return 3;
      default:            return 2;
    endcase
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {LW, SW, RT, BEQ, ADDI, JMP};
  endfunction

  task automatic check(input string name, input exp_t a, input exp_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, a, e);
    end
  endtask

  // zmode: 0 random Zero, 1 force Zero=1, 2 force Zero=0.
  // cut: assert reset asynchronously in the MEMWR step.
  task automatic run_instr(input logic [5:0] op, input int zmode, input bit cut);
    int n;
    int s;
    bit z[5];
    n = path_len(op);
    for (int c = 0; c < n; c++)
      z[c] = (zmode == 1) ? 1'b1 : (zmode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    for (int c = 0; c < n; c++) begin
      s = path_state(op, c);
      if (!(cut && s == 6))
        q.push_back(spec_out(s, z[c], (s == 2) && !is_legal(op)));
    end
    for (int c = 0; c < n; c++) begin
      s = path_state(op, c);
      bus.Zero = z[c];
      // Op only matters in DECODE and MEMADR; elsewhere it is noise.
      bus.Op = (s == 2 || s == 3) ? op : 6'($urandom);
      if (cut && s == 6) begin
        #2;
        checks++;
        if (bus.MemWrite !== 1'b1) begin
          errors++;
          $display("FAIL memwr_before_reset got=%b want=1", bus.MemWrite);
        end
        rst_n = 1'b0;
        repeat (3) q.push_back(spec_out(0, 1'b0, 1'b0));
        #1;
        check("async_reset", actual(), spec_out(0, 1'b0, 1'b0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    exp_t a, e;
    if (mon_en) begin
      a = actual();
      checks++;
      if (a.mw && a.rw) begin
        errors++;
        $display("FAIL mw_rw_exclusive t=%0t got=11 want=not both", $time);
      end
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow t=%0t got=%h want=queued entry", $time, a);
      end else begin
        e = q.pop_front();
        check("cycle", a, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops[6];
    logic [5:0] op;
    ops = '{LW, SW, RT, BEQ, ADDI, JMP};
    rst_n    = 1'b0;
    bus.Op   = 6'b000000;
    bus.Zero = 1'b0;
    repeat (4) q.push_back(spec_out(0, 1'b0, 1'b0));
    mon_en = 1'b1;
    #1;
    check("reset_state", actual(), spec_out(0, 1'b0, 1'b0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;

    run_instr(LW, 0, 1'b0);
    run_instr(SW, 0, 1'b0);
    run_instr(BEQ, 1, 1'b0);
    run_instr(BEQ, 2, 1'b0);
    run_instr(RT, 0, 1'b0);
    run_instr(ADDI, 0, 1'b0);
    run_instr(JMP, 0, 1'b0);
    run_instr(6'b111111, 0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 5)];
      run_instr(op, 0, 1'b0);
    end
    run_instr(SW, 0, 1'b1);
    run_instr(LW, 0, 1'b0);
    run_instr(BEQ, 0, 1'b0);

    for (int k = 0; k < 10 && q.size() != 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got=%0d want=0", q.size());
    end
    checks++;
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
